// File: rtl/ram_be_init.sv
`default_nettype none
// ============================================================================
//  Module   : ram_be_init
//  Brief    : On-chip RAM with per-lane write enables, 1- or 2-cycle read
//             latency, write-first collision forwarding and a hardware
//             zero-init sweep after reset and on request.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_be_init #(
    parameter int WORD_WIDTH  = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int LANE_WIDTH  = 4,
    parameter int RD_LAT      = 1
) (
    input  logic                               clk_i,
    input  logic                               arstn_i,
    input  logic                               wr_i,
    output logic                               ack_wr_o,
    input  logic [WORD_WIDTH-1:0]              wr_data_i,
    input  logic [WORD_WIDTH/LANE_WIDTH-1:0]   wr_be_i,
    input  logic [INDEX_WIDTH-1:0]             wr_index_i,
    input  logic                               rd_i,
    output logic                               ack_rd_o,
    output logic [WORD_WIDTH-1:0]              rd_data_o,
    input  logic [INDEX_WIDTH-1:0]             rd_index_i,
    input  logic                               clr_i,
    output logic                               init_busy_o
);

    localparam int DEPTH     = 2**INDEX_WIDTH;
    localparam int NUM_LANES = WORD_WIDTH / LANE_WIDTH;

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = {INDEX_WIDTH{1'b1}};

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [INDEX_WIDTH-1:0] sweep_cnt;
    logic                   in_run;
    logic                   sweep_en;

    logic [WORD_WIDTH-1:0]  mem [DEPTH];
    logic [WORD_WIDTH-1:0]  lane_mask;
    logic [WORD_WIDTH-1:0]  wr_merged;
    logic [WORD_WIDTH-1:0]  rd_word;

    logic                   wr_acc;
    logic                   rd_acc;
    logic                   rd_inflight;

    // ------------------------------------------------------------------
    // Lane enable expansion: one enable bit covers LANE_WIDTH data bits
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_mask[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wr_be_i[k]}};
    end

    // Merged word as it will be after the write; also the write-first
    // forwarding value when the read targets the same index this cycle.
    assign wr_merged = (mem[wr_index_i] & ~lane_mask) | (wr_data_i & lane_mask);
    assign rd_word   = (wr_acc && (wr_index_i == rd_index_i)) ? wr_merged : mem[rd_index_i];

    // clr_i takes priority: nothing is accepted in the cycle it is seen.
    // The ack cycles themselves never accept, giving at most one transfer
    // per two cycles on a held request.
    assign wr_acc = in_run && wr_i && !ack_wr_o && !clr_i;
    assign rd_acc = in_run && rd_i && !rd_inflight && !ack_rd_o && !clr_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register and sweep counter; counter is parked at 0 outside INIT
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= S_INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_en ? sweep_cnt + 1'b1 : '0;
        end
    end

    // Next-state: INIT runs one full pass, DRAIN waits out an in-flight read
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: begin
                if (sweep_cnt == LAST_INDEX) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (clr_i) begin
                    state_nxt = rd_inflight ? S_DRAIN : S_INIT;
                end
            end
            S_DRAIN: begin
                if (ack_rd_o) begin
                    state_nxt = S_INIT;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // State-decoded outputs and enables
    always_comb begin
        init_busy_o = (state == S_INIT);
        sweep_en    = (state == S_INIT);
        in_run      = (state == S_RUN);
    end

    // ------------------------------------------------------------------
    // Storage array (contents are not reset; the sweep zeroes them)
    // ------------------------------------------------------------------
    // Sweep writes zero one index per cycle; otherwise accepted lane writes
    always_ff @(posedge clk_i) begin
        if (sweep_en) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_acc) begin
            mem[wr_index_i] <= wr_merged;
        end
    end

    // Write acknowledge, one cycle after acceptance
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ack_wr_o <= 1'b0;
        end else begin
            ack_wr_o <= wr_acc;
        end
    end

    // ------------------------------------------------------------------
    // Read return path; any RD_LAT other than 2 builds the 1-cycle path
    // ------------------------------------------------------------------
    if (RD_LAT == 2) begin : g_lat2
        logic                  pipe_valid;
        logic [WORD_WIDTH-1:0] pipe_data;

        // Capture data at acceptance, present it one cycle later
        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                pipe_valid <= 1'b0;
                pipe_data  <= '0;
                ack_rd_o   <= 1'b0;
                rd_data_o  <= '0;
            end else begin
                pipe_valid <= rd_acc;
                if (rd_acc) begin
                    pipe_data <= rd_word;
                end
                ack_rd_o <= pipe_valid;
                if (pipe_valid) begin
                    rd_data_o <= pipe_data;
                end
            end
        end

        assign rd_inflight = pipe_valid;
    end else begin : g_lat1
        // Return data directly on the edge after acceptance
        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                ack_rd_o  <= 1'b0;
                rd_data_o <= '0;
            end else begin
                ack_rd_o <= rd_acc;
                if (rd_acc) begin
                    rd_data_o <= rd_word;
                end
            end
        end

        assign rd_inflight = 1'b0;
    end

endmodule
`default_nettype wire
